// File: rtl/v_alu_dispatch.sv
// Issue-side sequencer for the vector ALU lane: accepts one decoded instruction,
// reads both sources from the VRF, drives the ALU and hands the result to the VRF write port.
module v_alu_dispatch #(
    parameter int SEW       = 32,
    parameter int VLMAX     = 8,
    parameter int VALUOP_DW = 5,
    parameter int VREG_DW   = SEW * VLMAX,
    parameter int VREG_AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [VALUOP_DW-1:0] issue_opcode_i,
    input  logic [VREG_AW-1:0]   issue_vs1_i,
    input  logic [VREG_AW-1:0]   issue_vs2_i,
    input  logic [VREG_AW-1:0]   issue_vd_i,
    output logic [VREG_AW-1:0]   vrf_raddr1_o,
    output logic [VREG_AW-1:0]   vrf_raddr2_o,
    input  logic [VREG_DW-1:0]   vrf_rdata1_i,
    input  logic [VREG_DW-1:0]   vrf_rdata2_i,
    output logic [VALUOP_DW-1:0] valu_opcode_o,
    output logic [VREG_DW-1:0]   operand_v1_o,
    output logic [VREG_DW-1:0]   operand_v2_o,
    input  logic [VREG_DW-1:0]   valu_result_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [VREG_AW-1:0]   wb_addr_o,
    output logic [VREG_DW-1:0]   wb_data_o,
    output logic                 illegal_o,
    output logic [31:0]          retire_cnt_o,
    output logic [1:0]           dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // issue_ready_o depends only on the FSM state, never on wb_ready_i.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [VALUOP_DW-1:0] OP_NOP  = VALUOP_DW'(0);
    localparam logic [VALUOP_DW-1:0] OP_VADD = VALUOP_DW'(1);
    localparam logic [VALUOP_DW-1:0] OP_VMUL = VALUOP_DW'(2);

    logic [1:0]           r_state;
    logic [VALUOP_DW-1:0] r_opcode;
    logic [VREG_AW-1:0]   r_vd;
    logic [VREG_AW-1:0]   r_raddr1;
    logic [VREG_AW-1:0]   r_raddr2;
    logic [VREG_AW-1:0]   r_wb_addr;
    logic [VREG_DW-1:0]   r_wb_data;
    logic                 r_illegal;
    logic [31:0]          r_retire_cnt;

    logic w_accept;
    logic w_is_alu_op;
    logic w_in_exec;

    assign w_accept    = issue_valid_i && (r_state == S_IDLE);
    assign w_is_alu_op = (issue_opcode_i == OP_VADD) || (issue_opcode_i == OP_VMUL);
    assign w_in_exec   = (r_state == S_EXEC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_opcode     <= '0;
            r_vd         <= '0;
            r_raddr1     <= '0;
            r_raddr2     <= '0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_illegal    <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opcode <= issue_opcode_i;
                        r_vd     <= issue_vd_i;
                        // Read addresses only move for real ALU ops so they hold otherwise.
                        if (w_is_alu_op) begin
                            r_raddr1 <= issue_vs1_i;
                            r_raddr2 <= issue_vs2_i;
                            r_state  <= S_READ;
                        end else if (issue_opcode_i == OP_NOP) begin
                            r_retire_cnt <= r_retire_cnt + 32'd1;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_wb_data <= valu_result_i;
                    r_wb_addr <= r_vd;
                    r_state   <= S_WB;
                end
                S_WB: begin
                    if (wb_ready_i) begin
                        r_retire_cnt <= r_retire_cnt + 32'd1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign issue_ready_o = (r_state == S_IDLE);
    assign vrf_raddr1_o  = r_raddr1;
    assign vrf_raddr2_o  = r_raddr2;
    // The ALU sees a NOP with zero operands except during EXEC.
    assign valu_opcode_o = w_in_exec ? r_opcode : OP_NOP;
    assign operand_v1_o  = w_in_exec ? vrf_rdata1_i : '0;
    assign operand_v2_o  = w_in_exec ? vrf_rdata2_i : '0;
    assign wb_valid_o    = (r_state == S_WB);
    assign wb_addr_o     = r_wb_addr;
    assign wb_data_o     = r_wb_data;
    assign illegal_o     = r_illegal;
    assign retire_cnt_o  = r_retire_cnt;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_v_alu_dispatch.sv
// Directed bench for v_alu_dispatch with a small VRF and lane-wise ALU model around the DUT.
module tb_v_alu_dispatch;

    logic         clk;
    logic         rst;
    logic         issue_valid_i;
    logic         issue_ready_o;
    logic [4:0]   issue_opcode_i;
    logic [4:0]   issue_vs1_i;
    logic [4:0]   issue_vs2_i;
    logic [4:0]   issue_vd_i;
    logic [4:0]   vrf_raddr1_o;
    logic [4:0]   vrf_raddr2_o;
    logic [255:0] vrf_rdata1_i;
    logic [255:0] vrf_rdata2_i;
    logic [4:0]   valu_opcode_o;
    logic [255:0] operand_v1_o;
    logic [255:0] operand_v2_o;
    logic [255:0] valu_result_i;
    logic         wb_valid_o;
    logic         wb_ready_i;
    logic [4:0]   wb_addr_o;
    logic [255:0] wb_data_o;
    logic         illegal_o;
    logic [31:0]  retire_cnt_o;
    logic [1:0]   dbg_state_o;

    logic [255:0] vrf [32];
    logic [255:0] exp_q[$];
    logic [31:0]  exp_cnt;
    int           n_checks;
    int           n_errors;

    logic [255:0] v_a, v_b, v_m1, v_m2, exp_add, exp_mul, exp_dbl;

    v_alu_dispatch dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_opcode_i(issue_opcode_i), .issue_vs1_i(issue_vs1_i),
        .issue_vs2_i(issue_vs2_i), .issue_vd_i(issue_vd_i),
        .vrf_raddr1_o(vrf_raddr1_o), .vrf_raddr2_o(vrf_raddr2_o),
        .vrf_rdata1_i(vrf_rdata1_i), .vrf_rdata2_i(vrf_rdata2_i),
        .valu_opcode_o(valu_opcode_o), .operand_v1_o(operand_v1_o),
        .operand_v2_o(operand_v2_o), .valu_result_i(valu_result_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .illegal_o(illegal_o), .retire_cnt_o(retire_cnt_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock and VRF read port (data one cycle after the address)
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        vrf_rdata1_i <= vrf[vrf_raddr1_o];
        vrf_rdata2_i <= vrf[vrf_raddr2_o];
    end

    always_comb begin
        valu_result_i = '0;
        for (int l = 0; l < 8; l++) begin
            case (valu_opcode_o)
                5'd1: valu_result_i[l*32 +: 32] = operand_v1_o[l*32 +: 32] + operand_v2_o[l*32 +: 32];
                5'd2: valu_result_i[l*32 +: 32] = operand_v1_o[l*32 +: 32] * operand_v2_o[l*32 +: 32];
                default: valu_result_i[l*32 +: 32] = 32'd0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one instruction; returns at the falling edge of the cycle after acceptance.
    task automatic issue(input logic [4:0] op, input logic [4:0] vs1, input logic [4:0] vs2,
                         input logic [4:0] vd);
        @(negedge clk);
        chk("issue_ready_before", issue_ready_o, 1);
        issue_valid_i  = 1'b1;
        issue_opcode_i = op;
        issue_vs1_i    = vs1;
        issue_vs2_i    = vs2;
        issue_vd_i     = vd;
        @(negedge clk);
        issue_valid_i = 1'b0;
    endtask

    // Follow an accepted ALU op from READ through the writeback handshake.
    task automatic finish_alu(input logic [4:0] op, input logic [4:0] vs1, input logic [4:0] vs2,
                              input logic [4:0] vd, input logic [255:0] v1, input logic [255:0] v2,
                              input int stall);
        logic [255:0] exp_data;
        int n;
        chk("read_state", dbg_state_o, 1);
        chk("raddr1", vrf_raddr1_o, vs1);
        chk("raddr2", vrf_raddr2_o, vs2);
        chk("ready_low_read", issue_ready_o, 0);
        @(negedge clk);
        chk("exec_state", dbg_state_o, 2);
        chk("valu_opcode", valu_opcode_o, op);
        chk("operand_v1", operand_v1_o, v1);
        chk("operand_v2", operand_v2_o, v2);
        chk("wb_valid_exec", wb_valid_o, 0);
        n = 0;
        while (!wb_valid_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("wb_latency", n, 1);
        exp_data = exp_q.pop_front();
        for (int i = 0; i <= stall; i++) begin
            wb_ready_i = (i == stall);
            chk("wb_valid", wb_valid_o, 1);
            chk("wb_data", wb_data_o, exp_data);
            chk("wb_addr", wb_addr_o, vd);
            chk("ready_low_wb", issue_ready_o, 0);
            chk("retire_held", retire_cnt_o, exp_cnt);
            @(negedge clk);
        end
        wb_ready_i = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        chk("ready_after_wb", issue_ready_o, 1);
        chk("wb_valid_after", wb_valid_o, 0);
        chk("retire_after_wb", retire_cnt_o, exp_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 32'd0;
        rst = 1'b0;
        issue_valid_i = 1'b0; issue_opcode_i = '0;
        issue_vs1_i = '0; issue_vs2_i = '0; issue_vd_i = '0;
        wb_ready_i = 1'b0;
        for (int r = 0; r < 32; r++) vrf[r] = '0;
        for (int l = 0; l < 8; l++) begin
            v_a[l*32 +: 32]     = 32'(l + 1);
            v_b[l*32 +: 32]     = 32'd10;
            v_m1[l*32 +: 32]    = (l == 0) ? 32'h8000_0000 : 32'd3;
            v_m2[l*32 +: 32]    = (l == 0) ? 32'd2 : 32'd5;
            exp_add[l*32 +: 32] = 32'(l + 11);
            exp_mul[l*32 +: 32] = (l == 0) ? 32'd0 : 32'd15;
            exp_dbl[l*32 +: 32] = 32'd20;
        end
        vrf[1] = v_a; vrf[2] = v_b; vrf[4] = v_m1; vrf[5] = v_m2;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", issue_ready_o, 1);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_retire", retire_cnt_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_valu_op", valu_opcode_o, 0);
        rst = 1'b1;

        // VADD
        exp_q.push_back(exp_add);
        issue(5'd1, 5'd1, 5'd2, 5'd3);
        finish_alu(5'd1, 5'd1, 5'd2, 5'd3, v_a, v_b, 0);

        // VMUL with lane wrap
        exp_q.push_back(exp_mul);
        issue(5'd2, 5'd4, 5'd5, 5'd7);
        finish_alu(5'd2, 5'd4, 5'd5, 5'd7, v_m1, v_m2, 0);

        // Writeback backpressure for three cycles
        exp_q.push_back(exp_dbl);
        issue(5'd1, 5'd2, 5'd2, 5'd9);
        finish_alu(5'd1, 5'd2, 5'd2, 5'd9, v_b, v_b, 3);

        // NOP, NOP, illegal, VMUL back-to-back
        @(negedge clk);
        issue_valid_i = 1'b1; issue_opcode_i = 5'd0;
        @(negedge clk);
        chk("nop1_retire", retire_cnt_o, exp_cnt + 32'd1);
        chk("nop1_ready", issue_ready_o, 1);
        chk("nop1_wb_valid", wb_valid_o, 0);
        issue_opcode_i = 5'd0;
        @(negedge clk);
        chk("nop2_retire", retire_cnt_o, exp_cnt + 32'd2);
        chk("nop2_illegal", illegal_o, 0);
        issue_opcode_i = 5'd7;
        @(negedge clk);
        chk("ill_pulse", illegal_o, 1);
        chk("ill_retire", retire_cnt_o, exp_cnt + 32'd2);
        chk("ill_wb_valid", wb_valid_o, 0);
        chk("ill_raddr_hold", vrf_raddr1_o, 2);
        issue_opcode_i = 5'd2; issue_vs1_i = 5'd4; issue_vs2_i = 5'd5; issue_vd_i = 5'd6;
        exp_cnt = exp_cnt + 32'd2;
        exp_q.push_back(exp_mul);
        @(negedge clk);
        issue_valid_i = 1'b0;
        chk("ill_pulse_end", illegal_o, 0);
        finish_alu(5'd2, 5'd4, 5'd5, 5'd6, v_m1, v_m2, 0);

        // Asynchronous reset during EXEC
        issue(5'd1, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        chk("pre_rst_exec", dbg_state_o, 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_ready", issue_ready_o, 1);
        chk("arst_wb_valid", wb_valid_o, 0);
        chk("arst_retire", retire_cnt_o, 0);
        chk("arst_raddr1", vrf_raddr1_o, 0);
        chk("arst_valu_op", valu_opcode_o, 0);
        chk("arst_operand", operand_v1_o, 0);
        chk("arst_wb_addr", wb_addr_o, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_wb", wb_valid_o, 0);
        end
        exp_q.push_back(exp_add);
        issue(5'd1, 5'd1, 5'd2, 5'd3);
        finish_alu(5'd1, 5'd1, 5'd2, 5'd3, v_a, v_b, 0);

        // Retire counter wrap
        @(negedge clk);
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_retire_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        chk("wrap_preload", retire_cnt_o, exp_cnt);
        issue(5'd0, 5'd0, 5'd0, 5'd0);
        chk("wrap_zero", retire_cnt_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/v_alu_dispatch.md
# v_alu_dispatch

Issue-side sequencer for the vector ALU lane in the three-issue core. Accepts one decoded vector ALU instruction at a time over a valid/ready handshake and reads both source vector registers from the VRF. It drives the combinational vector ALU (opcode plus two `VREG_DW` operands), captures the lane-wise result, and presents it to the VRF write port with a valid/ready writeback handshake. It is the producer and consumer on the other side of the ALU's `opcode/operand/result` interface.

## Interface
- `SEW`, 32, element width in bits
- `VLMAX`, 8, elements per vector register
- `VALUOP_DW`, 5, ALU opcode width
- `VREG_DW`, 256, vector register width (`SEW*VLMAX`)
- `VREG_AW`, 5, vector register index width
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `issue_valid_i`  in  1  instruction offered
- `issue_ready_o`  out  1  dispatcher can accept
- `issue_opcode_i`  in  `VALUOP_DW`  0=NOP, 1=VADD, 2=VMUL, others illegal
- `issue_vs1_i`, `issue_vs2_i`, `issue_vd_i`  in  `VREG_AW` each  source and destination indices
- `vrf_raddr1_o`, `vrf_raddr2_o`  out  `VREG_AW`  VRF read addresses
- `vrf_rdata1_i`, `vrf_rdata2_i`  in  `VREG_DW`  VRF read data, valid the cycle after the address
- `valu_opcode_o`  out  `VALUOP_DW`  to ALU
- `operand_v1_o`, `operand_v2_o`  out  `VREG_DW`  to ALU
- `valu_result_i`  in  `VREG_DW`  from ALU, combinational in the same cycle
- `wb_valid_o`  out  1  writeback request
- `wb_ready_i`  in  1  VRF write port accepts
- `wb_addr_o`  out  `VREG_AW`  destination index
- `wb_data_o`  out  `VREG_DW`  result
- `illegal_o`  out  1  one-cycle pulse, illegal opcode dropped
- `retire_cnt_o`  out  32  count of completed instructions

## Operation
- **FSM states:** IDLE, READ, EXEC, WB.
- **IDLE**
  - `issue_ready_o=1` only in IDLE.
  - On `issue_valid_i`: latch opcode, vs1, vs2 and vd.
  - Opcode 1 or 2: go to READ.
  - Opcode 0 (NOP): retire immediately. Increment `retire_cnt_o`, stay in IDLE, no VRF read, no writeback.
  - Any other opcode: pulse `illegal_o` next cycle, stay in IDLE, no retire increment.
- **READ**
  - `vrf_raddr1_o/2_o` = latched vs1/vs2.
  - Go to EXEC unconditionally.
- **EXEC**
  - `valu_opcode_o` = latched opcode.
  - `operand_v1_o = vrf_rdata1_i`, `operand_v2_o = vrf_rdata2_i`.
  - Register `valu_result_i` into `wb_data_o` and vd into `wb_addr_o`.
  - Go to WB.
  - Outside EXEC: `valu_opcode_o=0` (NOP) and operands=0.
- **WB**
  - `wb_valid_o=1`. `wb_data_o` and `wb_addr_o` hold stable while `wb_ready_i=0`.
  - On `wb_ready_i=1`: go to IDLE and increment `retire_cnt_o`.
- **Read addresses:** `vrf_raddr*_o` are registered and hold their last value outside READ.
- **Arithmetic:** performed by the ALU, per `SEW` lane, modulo `2^SEW`. The dispatcher does not alter data.
- **Retire counter:** `retire_cnt_o` wraps from `2^32-1` to 0.
- **Reset** (any state, including mid-operation):
  - Go to IDLE and discard the in-flight instruction; no writeback is issued.
  - `issue_ready_o=1`, `wb_valid_o=0`, `illegal_o=0`, `retire_cnt_o=0`.
  - `wb_addr_o=0`, `wb_data_o=0`, `vrf_raddr*_o=0`, `valu_opcode_o=0`, operands=0.

## Timing
- **ALU instruction latency:** accept at cycle T.
  - T+1: READ.
  - T+2: EXEC.
  - T+3: `wb_valid_o` high at the earliest.
  - `issue_ready_o` high again in the cycle after the WB handshake.
  - Minimum 4 cycles per ALU instruction.
- **NOP:** accepted at T, `retire_cnt_o` updated at T+1, `issue_ready_o` stays high, so back-to-back NOPs run at 1 per cycle.
- **Illegal opcode:** accepted at T, `illegal_o` high for exactly cycle T+1; back-to-back illegal opcodes give consecutive pulses.
- **Handshakes:** both are sampled on the rising edge. No combinational path from `wb_ready_i` to `issue_ready_o`; no accept in the WB handshake cycle.
- **Held `issue_valid_i`:** a request held high while `issue_ready_o=0` is not accepted until IDLE and is never duplicated.

## Test plan
- **VADD:**
  - Stimulus: v1 lanes = 1..8, v2 lanes = 10, opcode 1, vd=3, `wb_ready_i=1`.
  - Required: `wb_valid_o` at T+3 with lanes 11..18, `wb_addr_o=3`, `retire_cnt_o` 0→1.
- **VMUL wrap:**
  - Stimulus: lane0 `0x80000000 × 2`, other lanes `3 × 5`.
  - Required: lane0=0, others=15.
- **Writeback backpressure:**
  - Stimulus: `wb_ready_i=0` for 3 cycles, then 1.
  - Required: `wb_valid_o` and `wb_data_o` stable for 4 cycles; `issue_ready_o` low throughout and high the following cycle; single retire.
- **NOP and illegal:**
  - Stimulus: opcodes 0, 0, 7, 2 offered back-to-back.
  - Required: two retires in consecutive cycles, one `illegal_o` pulse, then a normal 4-cycle VMUL; `wb_valid_o` never high for the NOP or illegal instructions.
- **Reset mid-operation:**
  - Stimulus: assert `rst=0` during EXEC.
  - Required: all outputs go to their reset values immediately (asynchronously); no `wb_valid_o` after release; the next instruction completes normally.
- **Counter wrap:**
  - Stimulus: preload by forcing `retire_cnt_o = 0xFFFFFFFF`, then retire one NOP.
  - Required: `retire_cnt_o` = 0.
